// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: owns the PC, runs the req/ready fetch handshake,
// buffers one response under stall and drives the IF/ID pipeline register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o,
    output logic [6:0]  id_op_o,
    output logic [2:0]  id_funct3_o,
    output logic [6:0]  id_funct7_o,
    output logic [4:0]  id_rs1_o,
    output logic [4:0]  id_rs2_o,
    output logic [4:0]  id_rd_o
);

    typedef enum logic [1:0] {IDLE, FETCH, BUF, KILL} state_t;

    state_t      state;
    logic [31:0] buf_pc, buf_inst;
    logic [31:0] target;
    logic        accept;
    logic        ld_new;
    logic [31:0] ld_pc, ld_inst;
    logic        unused_pc_lsbs;

    assign target         = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign accept         = !stall_i || !id_valid_o;

    // Which instruction (if any) is offered to IF/ID this cycle
    always_comb begin
        ld_new  = 1'b0;
        ld_pc   = imem_addr_o;
        ld_inst = imem_rdata_i;
        case (state)
            FETCH: ld_new = imem_ready_i && !redirect_i && accept;
            BUF: begin
                ld_new  = !stall_i && !redirect_i;
                ld_pc   = buf_pc;
                ld_inst = buf_inst;
            end
            default: ld_new = 1'b0;
        endcase
    end

    // The address register doubles as the killed-request address: it is held
    // unchanged throughout KILL until the orphaned transaction completes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            pc_o        <= RESET_PC;
            imem_req_o  <= 1'b0;
            imem_addr_o <= RESET_PC;
            buf_pc      <= 32'h0;
            buf_inst    <= NOP_INST;
        end else begin
            case (state)
                IDLE: begin
                    state       <= FETCH;
                    imem_req_o  <= 1'b1;
                    imem_addr_o <= pc_o;
                end
                FETCH: begin
                    if (redirect_i) begin
                        pc_o <= target;
                        if (imem_ready_i) imem_addr_o <= target;
                        else              state       <= KILL;
                    end else if (imem_ready_i) begin
                        pc_o <= pc_o + 32'd4;
                        if (accept) begin
                            imem_addr_o <= pc_o + 32'd4;
                        end else begin
                            buf_pc     <= imem_addr_o;
                            buf_inst   <= imem_rdata_i;
                            imem_req_o <= 1'b0;
                            state      <= BUF;
                        end
                    end
                end
                BUF: begin
                    if (redirect_i) begin
                        pc_o        <= target;
                        imem_addr_o <= target;
                        imem_req_o  <= 1'b1;
                        state       <= FETCH;
                    end else if (!stall_i) begin
                        imem_addr_o <= pc_o;
                        imem_req_o  <= 1'b1;
                        state       <= FETCH;
                    end
                end
                KILL: begin
                    if (redirect_i) pc_o <= target;
                    if (imem_ready_i) begin
                        imem_addr_o <= redirect_i ? target : pc_o;
                        state       <= FETCH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall holds, otherwise load or bubble
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= 32'h0;
            id_inst_o  <= NOP_INST;
        end else if (redirect_i) begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP_INST;
        end else if (stall_i && id_valid_o) begin
            id_valid_o <= 1'b1;
        end else if (ld_new) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= ld_pc;
            id_inst_o  <= ld_inst;
        end else begin
            id_valid_o <= 1'b0;
            id_inst_o  <= NOP_INST;
        end
    end

    assign id_op_o     = id_inst_o[6:0];
    assign id_funct3_o = id_inst_o[14:12];
    assign id_funct7_o = id_inst_o[31:25];
    assign id_rs1_o    = id_inst_o[19:15];
    assign id_rs2_o    = id_inst_o[24:20];
    assign id_rd_o     = id_inst_o[11:7];

endmodule
